// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between uart_tx_scheduler and its environment.
//   i_Req_Valid/i_Req_Byte/i_Req_Last : requester byte streams (byte n in [8n+7:8n])
//   o_Req_Ready                       : one-hot byte-accepted pulse
//   o_Grant                           : one-hot current owner, zero when idle
//   o_TX_DV/o_TX_Byte                 : start pulse and byte toward UART_TX
//   i_TX_Active/i_TX_Done             : status back from UART_TX
//   o_Timeout/o_Busy                  : gap-timeout pulse, scheduler not idle
// master = scheduler side, slave = requesters + transmitter side.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_Req_Valid;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   i_Req_Last;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Active;
  logic                 i_TX_Done;
  logic                 o_Timeout;
  logic                 o_Busy;

  modport master (
    input  i_Req_Valid, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
    output o_Req_Ready, o_Grant, o_TX_DV, o_TX_Byte, o_Timeout, o_Busy
  );

  modport slave (
    output i_Req_Valid, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
    input  o_Req_Ready, o_Grant, o_TX_DV, o_TX_Byte, o_Timeout, o_Busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ
// byte-stream requesters. A grant is held for a whole message, cut short
// by a MAX_BURST byte cap or by GAP_TIMEOUT idle cycles (0 = no timeout).
// Ports:
//   i_Clock : system clock, rising edge
//   i_Reset : synchronous, active-high reset
//   bus     : uart_tx_scheduler_if.master (requesters, grant, TX drive/status)
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int GAP_TIMEOUT = 1023
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  uart_tx_scheduler_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] GAP_MAX = '1;
  localparam logic [GW-1:0] GAP_LIM = GW'((GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0);
  localparam logic [7:0]    BURST   = 8'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d, own_q, own_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, ready_q, ready_d;
  logic [7:0]           byte_cnt_q, byte_cnt_d, tx_byte_q, tx_byte_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 last_q, last_d, tx_dv_q, tx_dv_d, tmo_q, tmo_d;

  logic                 pick_vld;
  logic [IW-1:0]        pick_idx;
  logic                 own_vld, own_last;
  logic [7:0]           own_byte;
  int                   cand;

  // First valid requester strictly after ptr, wrapping; ptr itself is last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!pick_vld && bus.i_Req_Valid[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
  end

  // Owner's lane; non-owner inputs never reach the datapath.
  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_byte = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (own_q == IW'(r)) begin
        own_vld  = bus.i_Req_Valid[r];
        own_last = bus.i_Req_Last[r];
        own_byte = bus.i_Req_Byte[8*r +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    own_d      = own_q;
    grant_d    = grant_q;
    byte_cnt_d = byte_cnt_q;
    gap_d      = gap_q;
    last_d     = last_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    ready_d    = '0;
    tmo_d      = 1'b0;
    case (state_q)
      IDLE: if (pick_vld) begin
        own_d      = pick_idx;
        grant_d    = NUM_REQ'(1) << pick_idx;
        byte_cnt_d = '0;
        gap_d      = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (own_vld) begin
          // Done is checked too so an issue never lands in the TX cleanup cycle.
          if (!bus.i_TX_Active && !bus.i_TX_Done) begin
            tx_dv_d    = 1'b1;
            tx_byte_d  = own_byte;
            ready_d    = grant_q;
            last_d     = own_last;
            byte_cnt_d = byte_cnt_q + 8'd1;
            gap_d      = '0;
            state_d    = WAIT;
          end
        end else begin
          if (gap_q != GAP_MAX) gap_d = gap_q + GW'(1);
          if (GAP_TIMEOUT != 0 && gap_q == GAP_LIM) begin
            tmo_d   = 1'b1;
            state_d = RELEASE;
          end
        end
      end
      WAIT: if (bus.i_TX_Done)
        state_d = (last_q || byte_cnt_q == BURST) ? RELEASE : SEND;
      RELEASE: begin
        // Always passes through IDLE so other requesters get a look-in.
        ptr_d   = own_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(NUM_REQ - 1);
      own_q      <= '0;
      grant_q    <= '0;
      byte_cnt_q <= '0;
      gap_q      <= '0;
      last_q     <= 1'b0;
      tx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
      ready_q    <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      own_q      <= own_d;
      grant_q    <= grant_d;
      byte_cnt_q <= byte_cnt_d;
      gap_q      <= gap_d;
      last_q     <= last_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      ready_q    <= ready_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.o_Req_Ready = ready_q;
  assign bus.o_Grant     = grant_q;
  assign bus.o_TX_DV     = tx_dv_q;
  assign bus.o_TX_Byte   = tx_byte_q;
  assign bus.o_Timeout   = tmo_q;
  assign bus.o_Busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: behavioural UART_TX (CLKS_PER_BIT=4, done
// held two cycles), per-requester byte queues, and a scoreboard of
// expected (requester, byte) issues checked on every o_TX_DV.
module tb_uart_tx_scheduler;
  localparam int NUM_REQ = 4, MAX_BURST = 4, GAP_TIMEOUT = 8, FRAME = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus();
  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .GAP_TIMEOUT(GAP_TIMEOUT))
    dut (.i_Clock(clk), .i_Reset(rst), .bus(bus));

  typedef struct { int req; logic [7:0] data; } exp_t;
  exp_t       sb[$];
  logic [8:0] rq [NUM_REQ][$];
  int vec_cnt = 0, err_cnt = 0, dv_cnt = 0, tmo_cnt = 0;
  logic tx_act_m = 1'b0, tx_done_m = 1'b0, force_act = 1'b0, mon_en = 1'b0;
  int busy_cnt = 0, done_cnt = 0;

  assign bus.i_TX_Active = tx_act_m | force_act;
  assign bus.i_TX_Done   = tx_done_m;

  // Transmitter model
  initial begin
    logic dv_s;
    forever begin
      @(negedge clk); dv_s = bus.o_TX_DV;
      @(posedge clk); #1;
      if (busy_cnt != 0) begin
        busy_cnt--;
        if (busy_cnt == 0) done_cnt = 2;
      end else if (done_cnt != 0) done_cnt--;
      else if (dv_s === 1'b1) busy_cnt = FRAME;
      tx_act_m  = (busy_cnt != 0);
      tx_done_m = (done_cnt != 0);
    end
  end

  // Requesters: present queue head, advance after the ready cycle ends
  initial begin
    logic [NUM_REQ-1:0] rdy_s;
    bus.i_Req_Valid = '0; bus.i_Req_Byte = '0; bus.i_Req_Last = '0;
    forever begin
      @(negedge clk); rdy_s = bus.o_Req_Ready;
      @(posedge clk); #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (rdy_s[r] === 1'b1 && rq[r].size() > 0) void'(rq[r].pop_front());
        if (rq[r].size() > 0) begin
          bus.i_Req_Valid[r] = 1'b1;
          bus.i_Req_Byte[8*r +: 8] = rq[r][0][7:0];
          bus.i_Req_Last[r] = rq[r][0][8];
        end else begin
          bus.i_Req_Valid[r] = 1'b0;
          bus.i_Req_Byte[8*r +: 8] = 8'h00;
          bus.i_Req_Last[r] = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    logic [NUM_REQ-1:0] exp_oh;
    logic act_p, done_p;
    act_p = 1'b0; done_p = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.o_Timeout === 1'b1) tmo_cnt++;
        if (bus.o_TX_DV === 1'b1) begin
          dv_cnt++;
          vec_cnt++;
          if (act_p !== 1'b0 || done_p !== 1'b0) begin
            err_cnt++;
            $display("FAIL issue_while_busy: active=%b done=%b, required 0/0", act_p, done_p);
          end
          vec_cnt++;
          if (sb.size() == 0) begin
            err_cnt++;
            $display("FAIL unexpected_issue: byte=%h ready=%b, required no issue", bus.o_TX_Byte, bus.o_Req_Ready);
          end else begin
            e = sb.pop_front();
            exp_oh = NUM_REQ'(1) << e.req;
            if (bus.o_TX_Byte !== e.data || bus.o_Req_Ready !== exp_oh || bus.o_Grant !== exp_oh) begin
              err_cnt++;
              $display("FAIL issue: byte=%h ready=%b grant=%b, required byte=%h ready/grant=%b",
                       bus.o_TX_Byte, bus.o_Req_Ready, bus.o_Grant, e.data, exp_oh);
            end
          end
        end else if (bus.o_Req_Ready !== '0) begin
          vec_cnt++; err_cnt++;
          $display("FAIL ready_without_dv: ready=%b, required 0", bus.o_Req_Ready);
        end
        act_p = bus.i_TX_Active; done_p = bus.i_TX_Done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [18:0] outs();
    return {bus.o_Req_Ready, bus.o_Grant, bus.o_TX_DV, bus.o_TX_Byte, bus.o_Timeout, bus.o_Busy};
  endfunction

  function automatic int rq_total();
    int n = 0;
    for (int r = 0; r < NUM_REQ; r++) n += rq[r].size();
    return n;
  endfunction

  task automatic push_byte(int r, logic [7:0] d, logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic expect_byte(int r, logic [7:0] d);
    exp_t e;
    e.req = r; e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while (n < budget && !(sb.size() == 0 && rq_total() == 0 && bus.o_Busy === 1'b0 &&
                           !tx_act_m && !tx_done_m)) begin
      @(posedge clk); #3; n++;
    end
    vec_cnt++;
    if (n >= budget) begin
      err_cnt++;
      $display("FAIL %s_drain: pending_exp=%0d pending_req=%0d busy=%b after %0d cycles, required drained",
               name, sb.size(), rq_total(), bus.o_Busy, n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (outs() !== '0) begin
      err_cnt++; $display("FAIL reset_outputs: got %h, required 0", outs());
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    push_byte(1, 8'hA5, 1'b0); push_byte(1, 8'h3C, 1'b0); push_byte(1, 8'h0F, 1'b1);
    expect_byte(1, 8'hA5); expect_byte(1, 8'h3C); expect_byte(1, 8'h0F);
    @(posedge clk); #2;
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.o_Grant !== 4'b0010 || bus.o_TX_DV !== 1'b0) begin
      err_cnt++; $display("FAIL latency_grant: grant=%b dv=%b, required 0010/0", bus.o_Grant, bus.o_TX_DV);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.o_TX_DV !== 1'b1 || bus.o_Req_Ready !== 4'b0010) begin
      err_cnt++; $display("FAIL latency_issue: dv=%b ready=%b, required 1/0010", bus.o_TX_DV, bus.o_Req_Ready);
    end
    wait_idle("single", 400);
    vec_cnt++;
    if (bus.o_Grant !== 4'b0000 || bus.o_TX_Byte !== 8'h0F) begin
      err_cnt++; $display("FAIL single_end: grant=%b byte=%h, required 0000/0f", bus.o_Grant, bus.o_TX_Byte);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      push_byte(0, 8'h10 + 8'(i), 1'b1); push_byte(2, 8'h20 + 8'(i), 1'b1);
      expect_byte(0, 8'h10 + 8'(i)); expect_byte(2, 8'h20 + 8'(i));
    end
    wait_idle("round_robin", 800);
  endtask

  task automatic test_burst_cap();
    int n = 0;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 6; i++) push_byte(3, 8'h30 + 8'(i), i == 5);
    for (int i = 0; i < 4; i++) expect_byte(3, 8'h30 + 8'(i));
    expect_byte(1, 8'h50); expect_byte(1, 8'h51);
    expect_byte(3, 8'h34); expect_byte(3, 8'h35);
    while (n < 300 && bus.o_Grant !== 4'b1000) begin @(negedge clk); n++; end
    vec_cnt++;
    if (n >= 300) begin
      err_cnt++; $display("FAIL burst_grant: grant=%b, required 1000", bus.o_Grant);
    end
    @(negedge clk);
    push_byte(1, 8'h50, 1'b0); push_byte(1, 8'h51, 1'b1);
    wait_idle("burst", 1200);
  endtask

  task automatic test_timeout();
    int n = 0, n_done = -1, t0;
    do_reset();
    t0 = tmo_cnt;
    @(negedge clk);
    push_byte(0, 8'h40, 1'b0); push_byte(2, 8'h60, 1'b1);
    expect_byte(0, 8'h40); expect_byte(2, 8'h60);
    while (n < 300 && bus.o_Timeout !== 1'b1) begin
      @(negedge clk); n++;
      if (n_done < 0 && bus.i_TX_Done === 1'b1) n_done = n;
    end
    vec_cnt++;
    if (n >= 300 || n - n_done != GAP_TIMEOUT + 1 || bus.o_Grant !== 4'b0001) begin
      err_cnt++;
      $display("FAIL timeout_pulse: cycles_after_done=%0d grant=%b, required %0d/0001",
               n - n_done, bus.o_Grant, GAP_TIMEOUT + 1);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.o_Grant !== 4'b0000 || bus.o_Timeout !== 1'b0) begin
      err_cnt++; $display("FAIL timeout_release: grant=%b tmo=%b, required 0000/0", bus.o_Grant, bus.o_Timeout);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.o_Grant !== 4'b0100) begin
      err_cnt++; $display("FAIL timeout_next: grant=%b, required 0100", bus.o_Grant);
    end
    wait_idle("timeout_a", 400);
    @(negedge clk);
    push_byte(0, 8'h41, 1'b1); expect_byte(0, 8'h41);
    wait_idle("timeout_b", 400);
    vec_cnt++;
    if (tmo_cnt - t0 != 1) begin
      err_cnt++; $display("FAIL timeout_count: got %0d, required 1", tmo_cnt - t0);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0, dv0;
    @(negedge clk);
    push_byte(1, 8'h70, 1'b0); push_byte(1, 8'h71, 1'b1);
    expect_byte(1, 8'h70);
    while (n < 100 && !tx_act_m) begin @(negedge clk); n++; end
    push_byte(0, 8'h80, 1'b1); push_byte(2, 8'h90, 1'b1);
    expect_byte(0, 8'h80); expect_byte(1, 8'h71); expect_byte(2, 8'h90);
    dv0 = dv_cnt;
    do_reset();
    vec_cnt++;
    if (outs() !== '0 || tx_act_m !== 1'b1) begin
      err_cnt++; $display("FAIL midframe_reset: outs=%h tx_active=%b, required 0/1", outs(), tx_act_m);
    end
    n = 0;
    while (n < 100 && tx_act_m) begin @(negedge clk); n++; end
    vec_cnt++;
    if (n >= 100 || dv_cnt != dv0) begin
      err_cnt++; $display("FAIL midframe_hold: issues=%0d, required 0 before active falls", dv_cnt - dv0);
    end
    wait_idle("midframe", 1000);
  endtask

  task automatic test_stall();
    int dv0, t0;
    @(posedge clk); #2 force_act = 1'b1;
    @(negedge clk);
    push_byte(2, 8'hC3, 1'b1); expect_byte(2, 8'hC3);
    dv0 = dv_cnt; t0 = tmo_cnt;
    repeat (20) @(posedge clk);
    #1;
    vec_cnt++;
    if (bus.o_Grant !== 4'b0100 || dv_cnt != dv0 || tmo_cnt != t0 || bus.o_TX_DV !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_hold: grant=%b issues=%0d timeouts=%0d, required 0100/0/0",
               bus.o_Grant, dv_cnt - dv0, tmo_cnt - t0);
    end
    force_act = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.o_TX_DV !== 1'b1 || bus.o_TX_Byte !== 8'hC3) begin
      err_cnt++; $display("FAIL stall_issue: dv=%b byte=%h, required 1/c3", bus.o_TX_DV, bus.o_TX_Byte);
    end
    wait_idle("stall", 400);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_timeout();
    test_reset_midframe();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
